// File: rtl/tdc_ctrl_reg_bank.sv
// Bank of N_REG JTAG user data registers sharing one shift chain, with bypass for
// unmapped select codes, shift-length checking, lock masking and a functional write/load path.
module tdc_ctrl_reg_bank #(
  parameter int unsigned                  DR_LENGTH   = 16,
  parameter int unsigned                  N_REG       = 4,
  parameter int unsigned                  SEL_W       = 2,
  parameter logic [N_REG*DR_LENGTH-1:0]   RESET_VALUE = '0,
  parameter logic [N_REG-1:0]             CAP_STATUS  = '0,
  parameter logic [N_REG-1:0]             LOCK_MASK   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         serial_in,
  input  logic                         shift,
  input  logic                         capture,
  input  logic                         update,
  output logic                         serial_out,
  input  logic                         write,
  input  logic                         load,
  input  logic [SEL_W-1:0]             write_sel,
  input  logic [DR_LENGTH-1:0]         write_data,
  input  logic [DR_LENGTH-1:0]         load_data,
  input  logic                         lock,
  input  logic [N_REG*DR_LENGTH-1:0]   status_in,
  output logic [N_REG*DR_LENGTH-1:0]   parallel_out,
  output logic [N_REG-1:0]             update_pulse,
  output logic                         len_err
);

  localparam int unsigned          CNT_W    = $clog2(DR_LENGTH + 2);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DR_LENGTH);
  localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(DR_LENGTH + 1);

  logic [DR_LENGTH-1:0] sr;
  logic                 byp;
  logic [CNT_W-1:0]     shift_cnt;

  logic                 sel_valid;
  logic                 sel_locked;
  logic [DR_LENGTH-1:0] cap_val;
  logic [N_REG-1:0]     sel_hit;
  logic [N_REG-1:0]     wr_hit;
  logic [N_REG-1:0]     commit;

  // One-hot decode keeps out-of-range select codes from ever indexing a register.
  always_comb begin
    sel_valid = 32'(sel) < N_REG;
    cap_val   = '0;
    sel_hit   = '0;
    wr_hit    = '0;
    for (int unsigned i = 0; i < N_REG; i++) begin
      sel_hit[i] = (32'(sel) == i);
      wr_hit[i]  = (32'(write_sel) == i);
      if (sel_hit[i]) begin
        cap_val = CAP_STATUS[i] ? status_in[i*DR_LENGTH +: DR_LENGTH]
                                : parallel_out[i*DR_LENGTH +: DR_LENGTH];
      end
    end
    sel_locked = lock && |(sel_hit & LOCK_MASK);
    commit     = (update && !sel_locked && shift_cnt == CNT_FULL) ? sel_hit : '0;
  end

  assign serial_out = sel_valid ? sr[0] : byp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr           <= '0;
      byp          <= 1'b0;
      shift_cnt    <= '0;
      parallel_out <= RESET_VALUE;
      update_pulse <= '0;
      len_err      <= 1'b0;
    end else begin
      update_pulse <= commit;
      if (sel_valid) begin
        if (capture) begin
          sr        <= cap_val;
          shift_cnt <= '0;
        end else if (shift) begin
          sr <= {serial_in, sr[DR_LENGTH-1:1]};
          if (shift_cnt != CNT_SAT) shift_cnt <= shift_cnt + 1'b1;
        end
        // A locked update leaves len_err alone even when the count is wrong.
        if (update && !sel_locked && shift_cnt != CNT_FULL) len_err <= 1'b1;
        else if (capture)                                   len_err <= 1'b0;
      end else begin
        if (capture)    byp <= 1'b0;
        else if (shift) byp <= serial_in;
      end
      for (int unsigned i = 0; i < N_REG; i++) begin
        if (commit[i])              parallel_out[i*DR_LENGTH +: DR_LENGTH] <= sr;
        else if (write && wr_hit[i]) parallel_out[i*DR_LENGTH +: DR_LENGTH] <= write_data;
        else if (load && wr_hit[i])  parallel_out[i*DR_LENGTH +: DR_LENGTH] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_tdc_ctrl_reg_bank.sv
// Directed bench for tdc_ctrl_reg_bank: table of full scans plus hand sequences for
// lock, functional writes, same-cycle commit/write, bypass and mid-scan reset.
module tb_tdc_ctrl_reg_bank;

  localparam logic [63:0] RV = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel, write_sel;
  logic        serial_in, shift, capture, update, serial_out;
  logic        write, load, lock, len_err;
  logic [15:0] write_data, load_data;
  logic [63:0] status_in, parallel_out;
  logic [3:0]  update_pulse;

  int checks = 0;
  int errors = 0;

  tdc_ctrl_reg_bank #(
    .DR_LENGTH   (16),
    .N_REG       (4),
    .SEL_W       (3),
    .RESET_VALUE (RV),
    .CAP_STATUS  (4'b0100),
    .LOCK_MASK   (4'b0001)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel),
    .serial_in    (serial_in),
    .shift        (shift),
    .capture      (capture),
    .update       (update),
    .serial_out   (serial_out),
    .write        (write),
    .load         (load),
    .write_sel    (write_sel),
    .write_data   (write_data),
    .load_data    (load_data),
    .lock         (lock),
    .status_in    (status_in),
    .parallel_out (parallel_out),
    .update_pulse (update_pulse),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] data;
    int unsigned n;
    logic        lk;
    logic        chk_out;
    logic [15:0] exp_out;
    logic [15:0] exp_po;
    logic [3:0]  exp_pulse;
    logic        exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic scan_shift(input logic [2:0] s, input logic [15:0] d, input int unsigned n,
                            output logic [15:0] so);
    sel     = s;
    capture = 1'b1;
    tick;
    capture = 1'b0;
    so      = '0;
    shift   = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      serial_in = (k < 16) ? d[k[3:0]] : 1'b0;
      if (k < 16) so[k[3:0]] = serial_out;
      tick;
    end
    shift     = 1'b0;
    serial_in = 1'b0;
  endtask

  logic [15:0] so;

  initial begin
    rst_n = 1'b0; sel = '0; write_sel = '0; serial_in = 0; shift = 0; capture = 0; update = 0;
    write = 0; load = 0; lock = 0; write_data = '0; load_data = '0;
    status_in = {16'hEEEE, 16'h1234, 16'hDDDD, 16'hCCCC};

    //          sel   data     n   lk chk exp_out   exp_po    pulse    len
    vecs[0] = '{3'd1, 16'hA5C3, 16, 0, 1, 16'h89AB, 16'hA5C3, 4'b0010, 1'b0};
    vecs[1] = '{3'd1, 16'h1111, 15, 0, 0, 16'h0000, 16'hA5C3, 4'b0000, 1'b1};
    vecs[2] = '{3'd1, 16'h2222, 17, 0, 0, 16'h0000, 16'hA5C3, 4'b0000, 1'b1};
    vecs[3] = '{3'd2, 16'h5555, 16, 0, 1, 16'h1234, 16'h5555, 4'b0100, 1'b0};
    vecs[4] = '{3'd0, 16'h7777, 16, 0, 1, 16'hCDEF, 16'h7777, 4'b0001, 1'b0};
    vecs[5] = '{3'd0, 16'hFFFF, 16, 1, 1, 16'h7777, 16'h7777, 4'b0000, 1'b0};
    vecs[6] = '{3'd3, 16'h9876, 16, 1, 1, 16'h0123, 16'h9876, 4'b1000, 1'b0};

    #12;
    check("rst_po", parallel_out, RV);
    check("rst_pulse", update_pulse, 4'b0);
    check("rst_len", len_err, 1'b0);
    check("rst_so", serial_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Update with no capture since reset: count is zero, so it is rejected.
    sel = 3'd1; update = 1'b1; tick; update = 1'b0;
    check("nocap_len", len_err, 1'b1);
    check("nocap_po", parallel_out, RV);
    check("nocap_pulse", update_pulse, 4'b0);

    for (int i = 0; i < 7; i++) begin
      lock = vecs[i].lk;
      scan_shift(vecs[i].sel, vecs[i].data, vecs[i].n, so);
      check($sformatf("v%0d_len_clr", i), len_err, 1'b0);
      if (vecs[i].chk_out) check($sformatf("v%0d_tdo", i), so, vecs[i].exp_out);
      update = 1'b1; tick; update = 1'b0;
      check($sformatf("v%0d_po", i), parallel_out[int'(vecs[i].sel)*16 +: 16], vecs[i].exp_po);
      check($sformatf("v%0d_pulse", i), update_pulse, vecs[i].exp_pulse);
      check($sformatf("v%0d_len", i), len_err, vecs[i].exp_len);
      tick;
      check($sformatf("v%0d_pulse_off", i), update_pulse, 4'b0);
      lock = 1'b0;
    end

    // Functional path ignores lock, never pulses, and ranks write above load.
    lock = 1'b1; write = 1'b1; write_sel = 3'd0; write_data = 16'h0F0F; tick;
    write = 1'b0; lock = 1'b0;
    check("lockwr_po0", parallel_out[15:0], 16'h0F0F);
    check("lockwr_pulse", update_pulse, 4'b0);
    load = 1'b1; write_sel = 3'd1; load_data = 16'hBEEF; tick; load = 1'b0;
    check("load_po1", parallel_out[31:16], 16'hBEEF);
    write = 1'b1; load = 1'b1; write_sel = 3'd2; write_data = 16'hAAA1; load_data = 16'hBBB2; tick;
    write = 1'b0; load = 1'b0;
    check("wr_over_ld", parallel_out[47:32], 16'hAAA1);
    write = 1'b1; write_sel = 3'd5; write_data = 16'hDEAD; tick; write = 1'b0;
    check("wr_badsel", parallel_out, 64'h9876_AAA1_BEEF_0F0F);

    // Commit and write in the same cycle.
    scan_shift(3'd3, 16'hAAAA, 16, so);
    update = 1'b1; write = 1'b1; write_sel = 3'd3; write_data = 16'h5555; tick;
    update = 1'b0; write = 1'b0;
    check("same_reg_po3", parallel_out[63:48], 16'hAAAA);
    check("same_reg_pulse", update_pulse, 4'b1000);
    tick;
    scan_shift(3'd3, 16'h3C3C, 16, so);
    update = 1'b1; write = 1'b1; write_sel = 3'd0; write_data = 16'h1111; tick;
    update = 1'b0; write = 1'b0;
    check("two_reg_po", parallel_out, 64'h3C3C_AAA1_BEEF_1111);
    check("two_reg_pulse", update_pulse, 4'b1000);
    tick;

    // Bypass: one-bit delay, capture clears, update does nothing.
    sel = 3'd4; shift = 1'b1; serial_in = 1'b1; tick; shift = 1'b0;
    check("byp_pre", serial_out, 1'b1);
    capture = 1'b1; tick; capture = 1'b0;
    check("byp_cap", serial_out, 1'b0);
    shift = 1'b1;
    serial_in = 1'b1; tick; check("byp_b0", serial_out, 1'b1);
    serial_in = 1'b0; tick; check("byp_b1", serial_out, 1'b0);
    serial_in = 1'b1; tick; check("byp_b2", serial_out, 1'b1);
    shift = 1'b0; serial_in = 1'b0;
    update = 1'b1; tick; update = 1'b0;
    check("byp_upd_po", parallel_out, 64'h3C3C_AAA1_BEEF_1111);
    check("byp_upd_pulse", update_pulse, 4'b0);
    check("byp_upd_len", len_err, 1'b0);
    // Bypass traffic must leave reg3's count at full length.
    sel = 3'd3; update = 1'b1; tick; update = 1'b0;
    check("byp_keeps_cnt", update_pulse, 4'b1000);
    tick;

    // Reset in the middle of a scan, with len_err set beforehand.
    sel = 3'd1; capture = 1'b1; tick; capture = 1'b0;
    update = 1'b1; tick; update = 1'b0;
    check("mid_len_set", len_err, 1'b1);
    shift = 1'b1; serial_in = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_po", parallel_out, RV);
    check("mid_rst_pulse", update_pulse, 4'b0);
    check("mid_rst_len", len_err, 1'b0);
    check("mid_rst_so", serial_out, 1'b0);
    shift = 1'b0; serial_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    update = 1'b1; tick; update = 1'b0;
    check("post_rst_len", len_err, 1'b1);
    check("post_rst_po", parallel_out, RV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
